cpu_sram_arbiter: RTL and testbench

CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

---
 rtl/cpu_sram_arbiter.sv | 135 +++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-like master port with an
// in-order owner FIFO for response routing. Define ARB_RR_EN for round-robin ties.
module cpu_sram_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,

   input  logic                     inst_req,
   input  logic                     inst_wr,
   input  logic [1:0]               inst_size,
   input  logic [3:0]               inst_wstrb,
   input  logic [31:0]              inst_addr,
   input  logic [31:0]              inst_wdata,
   output logic                     inst_addr_ok,
   output logic                     inst_data_ok,
   output logic [31:0]              inst_rdata,

   input  logic                     data_req,
   input  logic                     data_wr,
   input  logic [1:0]               data_size,
   input  logic [3:0]               data_wstrb,
   input  logic [31:0]              data_addr,
   input  logic [31:0]              data_wdata,
   output logic                     data_addr_ok,
   output logic                     data_data_ok,
   output logic [31:0]              data_rdata,

   output logic                     m_req,
   output logic                     m_wr,
   output logic [1:0]               m_size,
   output logic [3:0]               m_wstrb,
   output logic [31:0]              m_addr,
   output logic [31:0]              m_wdata,
   input  logic                     m_addr_ok,
   input  logic                     m_data_ok,
   input  logic [31:0]              m_rdata,

   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     arb_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0] owner_q, owner_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic full, empty, grant_data, hs, pop, head;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = owner_q[rd_ptr_q];

`ifdef ARB_RR_EN
   // Last granted owner at an address handshake; 0 = inst
   logic rr_last_q, rr_last_d;

   always_comb begin
      grant_data = data_req;
      if (inst_req && data_req) grant_data = ~rr_last_q;
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (hs) rr_last_d = grant_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) rr_last_q <= 1'b0;
      else         rr_last_q <= rr_last_d;
   end
`else
   always_comb begin
      grant_data = data_req;
   end
`endif

   // Request mux, handshakes and response routing; all quiet while in reset
   always_comb begin
      m_req        = resetn & (inst_req | data_req) & ~full;
      m_wr         = 1'b0;
      m_size       = '0;
      m_wstrb      = '0;
      m_addr       = '0;
      m_wdata      = '0;
      if (m_req) begin
         m_wr    = grant_data ? data_wr    : inst_wr;
         m_size  = grant_data ? data_size  : inst_size;
         m_wstrb = grant_data ? data_wstrb : inst_wstrb;
         m_addr  = grant_data ? data_addr  : inst_addr;
         m_wdata = grant_data ? data_wdata : inst_wdata;
      end
      hs           = m_req & m_addr_ok;
      inst_addr_ok = hs & ~grant_data;
      data_addr_ok = hs &  grant_data;
      pop          = resetn & m_data_ok & ~empty;
      inst_data_ok = pop & ~head;
      data_data_ok = pop &  head;
      inst_rdata   = m_rdata;
      data_rdata   = m_rdata;
   end

   always_comb begin
      owner_d = owner_q;
      if (hs) owner_d[wr_ptr_q] = grant_data;
      wr_ptr_d = wr_ptr_q + PW'(hs);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(hs) - CW'(pop);
      err_d    = err_q | (m_data_ok & empty);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign outstanding = cnt_q;
   assign arb_err     = err_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: queue-based owner model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_sram_arbiter;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [$clog2(DEPTH):0] outstanding;
   logic        arb_err;

   int n_total = 0;
   int n_pass  = 0;

   cpu_sram_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .outstanding(outstanding), .arb_err(arb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Model: list of owners awaiting responses (0=inst,1=data), sticky error, last winner
   bit owners[$];
   bit mdl_err  = 1'b0;
   bit mdl_last = 1'b0;

   always @(negedge clk) begin
      bit any, full, win_data, e_req, e_hs, e_pop, head;
      any  = inst_req | data_req;
      full = (owners.size() == DEPTH);
      if (inst_req && data_req) begin
`ifdef ARB_RR_EN
         win_data = !mdl_last;
`else
         win_data = 1'b1;
`endif
      end else begin
         win_data = data_req;
      end
      e_req = resetn && any && !full;
      e_hs  = e_req && m_addr_ok;
      e_pop = resetn && m_data_ok && owners.size() != 0;
      head  = (owners.size() != 0) ? owners[0] : 1'b0;

      chk("m_req", 32'(m_req), 32'(e_req));
      chk("m_wr", 32'(m_wr), e_req ? 32'(win_data ? data_wr : inst_wr) : 32'd0);
      chk("m_size", 32'(m_size), e_req ? 32'(win_data ? data_size : inst_size) : 32'd0);
      chk("m_wstrb", 32'(m_wstrb), e_req ? 32'(win_data ? data_wstrb : inst_wstrb) : 32'd0);
      chk("m_addr", m_addr, e_req ? (win_data ? data_addr : inst_addr) : 32'd0);
      chk("m_wdata", m_wdata, e_req ? (win_data ? data_wdata : inst_wdata) : 32'd0);
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_hs && !win_data));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_hs && win_data));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(e_pop && !head));
      chk("data_data_ok", 32'(data_data_ok), 32'(e_pop && head));
      chk("inst_rdata", inst_rdata, m_rdata);
      chk("data_rdata", data_rdata, m_rdata);
      chk("outstanding", 32'(outstanding), 32'(owners.size()));
      chk("arb_err", 32'(arb_err), 32'(mdl_err));

      if (!resetn) begin
         owners.delete();
         mdl_err  = 1'b0;
         mdl_last = 1'b0;
      end else begin
         if (m_data_ok && owners.size() == 0) mdl_err = 1'b1;
         if (e_pop) void'(owners.pop_front());
         if (e_hs) begin
            owners.push_back(win_data);
            mdl_last = win_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'h0;
      inst_addr = 32'h0; inst_wdata = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
      data_addr = 32'h0; data_wdata = 32'h0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      idle();
      inst_req = 1'b1; m_addr_ok = 1'b1;
      tick(); #2;
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_arb_err", 32'(arb_err), 32'd0);
      tick();

      // Single transaction with zero-latency response
      resetn = 1'b1; idle();
      inst_req = 1'b1; inst_addr = 32'hbfc00000; inst_size = 2'd2; m_addr_ok = 1'b1;
      #2;
      chk("single_addr_ok", 32'(inst_addr_ok), 32'd1);
      chk("single_m_addr", m_addr, 32'hbfc00000);
      tick(); idle();
      m_data_ok = 1'b1; m_rdata = 32'h24020001;
      #2;
      chk("single_out1", 32'(outstanding), 32'd1);
      chk("single_data_ok", 32'(inst_data_ok), 32'd1);
      chk("single_rdata", inst_rdata, 32'h24020001);
      tick(); idle(); #2;
      chk("single_out0", 32'(outstanding), 32'd0);

      // Tie for four cycles
      for (int i = 0; i < 4; i++) begin
         logic exp_d;
         tick();
         inst_req = 1'b1; inst_addr = 32'h1000 + 32'(i * 4);
         data_req = 1'b1; data_addr = 32'h2000 + 32'(i * 4); data_wr = 1'b1;
         data_wstrb = 4'hf; data_wdata = 32'hd0d0_0000 + 32'(i); m_addr_ok = 1'b1;
         #2;
`ifdef ARB_RR_EN
         exp_d = (i % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         chk("tie_data_ok", 32'(data_addr_ok), 32'(exp_d));
         chk("tie_inst_ok", 32'(inst_addr_ok), 32'(!exp_d));
      end
      tick(); idle(); #2;
      chk("tie_out4", 32'(outstanding), 32'd4);
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); m_data_ok = 1'b1; m_rdata = 32'hcafe_0000 + 32'(i);
      end
      tick(); idle(); #2;
      chk("tie_drained", 32'(outstanding), 32'd0);

      // Full: four accepted, fifth blocked even when a response pops
      for (int i = 0; i < 4; i++) begin
         tick(); inst_req = 1'b1; inst_addr = 32'h3000 + 32'(i * 4); m_addr_ok = 1'b1;
         #2; chk("full_fill_ok", 32'(inst_addr_ok), 32'd1);
      end
      tick(); #2;
      chk("full_m_req", 32'(m_req), 32'd0);
      chk("full_out4", 32'(outstanding), 32'd4);
      tick(); m_data_ok = 1'b1; m_rdata = 32'h5555aaaa; #2;
      chk("full_pop_m_req", 32'(m_req), 32'd0);
      chk("full_pop_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("full_pop_data_ok", 32'(inst_data_ok), 32'd1);
      tick(); m_data_ok = 1'b0; #2;
      chk("full_out3", 32'(outstanding), 32'd3);
      chk("full_resume", 32'(inst_addr_ok), 32'd1);
      tick(); idle(); #2;
      chk("full_out4b", 32'(outstanding), 32'd4);
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); m_data_ok = 1'b1;
      end
      tick(); idle();

      // Interleaved issue, in-order return
      inst_req = 1'b1; inst_addr = 32'h0; m_addr_ok = 1'b1;
      tick(); idle(); data_req = 1'b1; data_addr = 32'h100; m_addr_ok = 1'b1;
      tick(); idle(); inst_req = 1'b1; inst_addr = 32'h4; m_addr_ok = 1'b1;
      tick(); idle(); m_data_ok = 1'b1; #2;
      chk("il_1_inst", 32'(inst_data_ok), 32'd1);
      chk("il_1_data", 32'(data_data_ok), 32'd0);
      tick(); #2;
      chk("il_2_inst", 32'(inst_data_ok), 32'd0);
      chk("il_2_data", 32'(data_data_ok), 32'd1);
      tick(); #2;
      chk("il_3_inst", 32'(inst_data_ok), 32'd1);
      chk("il_3_data", 32'(data_data_ok), 32'd0);
      tick(); idle();

      // Push and pop in the same cycle
      inst_req = 1'b1; inst_addr = 32'h200; m_addr_ok = 1'b1;
      tick(); idle(); data_req = 1'b1; data_addr = 32'h204; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      #2; chk("pp_inst_ok", 32'(inst_data_ok), 32'd1);
      tick(); idle(); #2;
      chk("pp_out1", 32'(outstanding), 32'd1);
      m_data_ok = 1'b1; #1;
      chk("pp_data_ok", 32'(data_data_ok), 32'd1);
      tick(); idle();

      // Stray response sets sticky error
      m_data_ok = 1'b1; #2;
      chk("err_no_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);
      tick(); idle(); #2;
      chk("err_set", 32'(arb_err), 32'd1);
      tick(); tick(); #2;
      chk("err_hold", 32'(arb_err), 32'd1);

      // Reset with two outstanding discards them
      inst_req = 1'b1; m_addr_ok = 1'b1;
      tick(); tick(); idle(); #2;
      chk("pre_rst_out2", 32'(outstanding), 32'd2);
      tick(); resetn = 1'b0; inst_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1; #2;
      chk("in_rst_m_req", 32'(m_req), 32'd0);
      chk("in_rst_data_ok", 32'(inst_data_ok), 32'd0);
      tick(); resetn = 1'b1; idle(); #2;
      chk("post_rst_out", 32'(outstanding), 32'd0);
      chk("post_rst_err", 32'(arb_err), 32'd0);
      m_data_ok = 1'b1;
      tick(); idle(); #2;
      chk("late_resp_err", 32'(arb_err), 32'd1);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
